// File: rtl/myproject_mac_pipe_pkg.sv
// Shared types, defaults and helpers for the pipelined signed MAC.
package myproject_mac_pipe_pkg;

   localparam int unsigned ACC_WIDTH_DEF = 48;
   // Wide container used by the sign-extension helper; covers every legal width.
   localparam int unsigned EXT_W = 128;

   // Per-sample sideband that travels alongside the product.
   typedef struct packed {
      logic vld;
      logic acc_en;
      logic acc_clr;
   } sb_t;

   localparam int unsigned SB_W = $bits(sb_t);

   // Sign-extend the low from_w bits of v to the full container width.
   function automatic logic [EXT_W-1:0] sext_to_acc(input logic [EXT_W-1:0] v,
                                                    input int unsigned      from_w);
      logic [EXT_W-1:0] mask;
      mask = (EXT_W'(1) << from_w) - EXT_W'(1);
      if ((v & (EXT_W'(1) << (from_w - 1))) != '0) begin
         return v | ~mask;
      end
      return v & mask;
   endfunction

   // Signed add overflow: operands agree in sign, result does not.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/myproject_mac_pipe_mul.sv
// Pure signed multiplier with STAGES register stages (operands, then product),
// left without reset so the tools can retime it into DSP pipeline registers.
module myproject_mac_pipe_mul #(
   parameter int unsigned A_WIDTH = 16,
   parameter int unsigned B_WIDTH = 27,
   parameter int unsigned STAGES  = 2
) (
   input  logic                                clk,
   input  logic                                ce,
   input  logic signed [A_WIDTH-1:0]           a_i,
   input  logic signed [B_WIDTH-1:0]           b_i,
   output logic signed [A_WIDTH+B_WIDTH-1:0]   p_o
);

   localparam int unsigned FULL_W = A_WIDTH + B_WIDTH;

   if (STAGES == 0) begin : g_comb
      // No registers: product straight from the inputs.
      assign p_o = FULL_W'(a_i) * FULL_W'(b_i);
   end else begin : g_piped
      logic signed [A_WIDTH-1:0] a_q;
      logic signed [B_WIDTH-1:0] b_q;
      logic signed [FULL_W-1:0]  prod_c;

      // Operand capture stage.
      always_ff @(posedge clk) begin
         if (ce) begin
            a_q <= a_i;
            b_q <= b_i;
         end
      end

      assign prod_c = FULL_W'(a_q) * FULL_W'(b_q);

      if (STAGES == 1) begin : g_one
         assign p_o = prod_c;
      end else begin : g_prod
         localparam int unsigned PW = (STAGES - 1) * FULL_W;
         logic [PW-1:0] p_q;

         // Product delay line; newest entry at the bottom, oldest at the top.
         always_ff @(posedge clk) begin
            if (ce) begin
               p_q <= PW'({p_q, prod_c});
            end
         end

         assign p_o = p_q[PW-1 -: FULL_W];
      end
   end

endmodule

// File: rtl/myproject_mac_pipe.sv
// Pipelined signed multiply / multiply-accumulate with valid tracking,
// clock enable, per-sample accumulator clear and sticky overflow.
module myproject_mac_pipe
   import myproject_mac_pipe_pkg::*;
#(
   parameter int unsigned A_WIDTH   = 16,
   parameter int unsigned B_WIDTH   = 27,
   parameter int unsigned P_WIDTH   = 43,
   parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
   parameter int unsigned NUM_STAGE = 3
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst,
   input  logic                        ce,
   input  logic                        in_valid,
   input  logic signed [A_WIDTH-1:0]   din0,
   input  logic signed [B_WIDTH-1:0]   din1,
   input  logic                        acc_en,
   input  logic                        acc_clr,
   output logic                        out_valid,
   output logic [ACC_WIDTH-1:0]        dout,
   output logic                        acc_ovf
);

   localparam int unsigned FULL_W = A_WIDTH + B_WIDTH;
   localparam int unsigned MUL_ST = NUM_STAGE - 1;

   logic signed [FULL_W-1:0] prod_full;
   logic [P_WIDTH-1:0]       prod_p;
   logic [ACC_WIDTH-1:0]     prod_acc;
   logic [ACC_WIDTH-1:0]     sum_c;
   sb_t                      sb_in;
   sb_t                      sb_fin;

   logic                 out_valid_q, out_valid_d;
   logic [ACC_WIDTH-1:0] dout_q, dout_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                 ovf_q, ovf_d;

   myproject_mac_pipe_mul #(
      .A_WIDTH (A_WIDTH),
      .B_WIDTH (B_WIDTH),
      .STAGES  (MUL_ST)
   ) u_mul (
      .clk (ap_clk),
      .ce  (ce),
      .a_i (din0),
      .b_i (din1),
      .p_o (prod_full)
   );

   assign sb_in = '{vld: in_valid, acc_en: acc_en, acc_clr: acc_clr};

   if (MUL_ST == 0) begin : g_sb_direct
      assign sb_fin = sb_in;
   end else begin : g_sb_pipe
      localparam int unsigned SBW = MUL_ST * SB_W;
      logic [SBW-1:0] sb_q;

      // Sideband delay line matched to the multiplier latency; reset kills in-flight valids.
      always_ff @(posedge ap_clk or posedge ap_rst) begin
         if (ap_rst) begin
            sb_q <= '0;
         end else if (ce) begin
            sb_q <= SBW'({sb_q, sb_in});
         end
      end

      assign sb_fin = sb_t'(sb_q[SBW-1 -: SB_W]);
   end

   // Truncate or extend the full product to P_WIDTH, then extend to the accumulator.
   assign prod_p   = P_WIDTH'(sext_to_acc(EXT_W'(prod_full), FULL_W));
   assign prod_acc = ACC_WIDTH'(sext_to_acc(EXT_W'(prod_p), P_WIDTH));
   assign sum_c    = acc_q + prod_acc;

   // Final stage next-state: result select, accumulator update and sticky overflow.
   always_comb begin
      out_valid_d = sb_fin.vld;
      dout_d      = dout_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      if (sb_fin.vld) begin
         if (sb_fin.acc_en) begin
            if (sb_fin.acc_clr) begin
               acc_d = prod_acc;
               ovf_d = 1'b0;
            end else begin
               acc_d = sum_c;
               ovf_d = ovf_q | add_ovf(acc_q[ACC_WIDTH-1], prod_acc[ACC_WIDTH-1],
                                       sum_c[ACC_WIDTH-1]);
            end
            dout_d = acc_d;
         end else begin
            dout_d = prod_acc;
         end
      end
   end

   // Final stage registers, frozen while ce is low.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
      end else if (ce) begin
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Scoreboard bench for myproject_mac_pipe (defaults) plus a NUM_STAGE=1 instance.
module tb_myproject_mac_pipe;

   localparam int unsigned NS = 3;

   logic ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   // Main DUT (default parameters)
   logic               ap_rst, ce, in_valid, acc_en, acc_clr;
   logic signed [15:0] din0;
   logic signed [26:0] din1;
   logic               out_valid, acc_ovf;
   logic [47:0]        dout;

   // Single-stage DUT
   logic               rst1, ce1, in_valid1, acc_en1, acc_clr1;
   logic signed [15:0] din0_1;
   logic signed [26:0] din1_1;
   logic               out_valid1, acc_ovf1;
   logic [47:0]        dout1;

   myproject_mac_pipe dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid),
      .din0(din0), .din1(din1), .acc_en(acc_en), .acc_clr(acc_clr),
      .out_valid(out_valid), .dout(dout), .acc_ovf(acc_ovf)
   );

   myproject_mac_pipe #(.NUM_STAGE(1)) dut1 (
      .ap_clk(ap_clk), .ap_rst(rst1), .ce(ce1), .in_valid(in_valid1),
      .din0(din0_1), .din1(din1_1), .acc_en(acc_en1), .acc_clr(acc_clr1),
      .out_valid(out_valid1), .dout(dout1), .acc_ovf(acc_ovf1)
   );

   typedef struct {
      logic [47:0] d;
      logic        ovf;
      int unsigned at_edge;
   } exp_t;

   exp_t        q[$];
   int          errs = 0;
   int          checks = 0;
   int unsigned ecnt = 0;
   logic        last_ce = 1'b1;
   logic        pv = 1'b0;
   logic [47:0] pd = '0;
   logic        po = 1'b0;

   // Count enabled edges and remember whether the last edge was enabled.
   always @(posedge ap_clk) begin
      if (ce) ecnt <= ecnt + 1;
      last_ce <= ce;
   end

   // Monitor: pop and compare on each new output; check hold during stalls.
   always @(negedge ap_clk) begin
      exp_t e;
      if (!ap_rst) begin
         if (!last_ce) begin
            checks++;
            if (out_valid !== pv || dout !== pd || acc_ovf !== po) begin
               errs++;
               $display("FAIL stall_hold: got v=%0b d=%0d o=%0b want v=%0b d=%0d o=%0b",
                        out_valid, $signed(dout), acc_ovf, pv, $signed(pd), po);
            end
         end else if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
               errs++;
               $display("FAIL spurious_out: got out_valid=1 d=%0d want out_valid=0 at edge %0d",
                        $signed(dout), ecnt);
            end else begin
               e = q.pop_front();
               if (dout !== e.d || acc_ovf !== e.ovf || ecnt != e.at_edge) begin
                  errs++;
                  $display("FAIL result: got d=%0d o=%0b edge=%0d want d=%0d o=%0b edge=%0d",
                           $signed(dout), acc_ovf, ecnt, $signed(e.d), e.ovf, e.at_edge);
               end
            end
         end
      end
      pv = out_valid;
      pd = dout;
      po = acc_ovf;
   end

   task automatic chk(input string name, input logic [47:0] got, input logic [47:0] want);
      checks++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got %0d want %0d", name, $signed(got), $signed(want));
      end
   endtask

   // Present one sample for one edge; optionally register its expected result.
   task automatic send(input logic v, input int a, input int b, input logic en, input logic clr,
                       input logic push, input logic [47:0] ed, input logic eo);
      in_valid = v; din0 = 16'(a); din1 = 27'(b); acc_en = en; acc_clr = clr;
      if (push) q.push_back('{d: ed, ovf: eo, at_edge: ecnt + NS});
      @(posedge ap_clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge ap_clk); #1;
      end
   endtask

   task automatic stall(input int n);
      ce = 1'b0; in_valid = 1'b1; din0 = 16'(99); din1 = 27'(99); acc_en = 1'b1; acc_clr = 1'b1;
      repeat (n) begin
         @(posedge ap_clk); #1;
      end
      ce = 1'b1;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge ap_clk);
      @(posedge ap_clk); #1;
      if (q.size() != 0) begin
         errs++; checks++;
         $display("FAIL drain_timeout: got %0d pending want 0", q.size());
         q.delete();
      end
      idle(2);
   endtask

   task automatic ovf_chain();
      for (int k = 1; k <= 64; k++) begin
         send(1, -32768, -67108864, 1, (k == 1), 1, 48'(k) << 41, (k == 64));
      end
   endtask

   // Drive the single-stage DUT for one edge and check its output right after.
   task automatic send1(input int a, input int b, input logic en, input logic clr,
                        input logic [47:0] ed, input string name);
      in_valid1 = 1'b1; din0_1 = 16'(a); din1_1 = 27'(b); acc_en1 = en; acc_clr1 = clr;
      @(posedge ap_clk); #1;
      in_valid1 = 1'b0;
      chk({name, "_valid"}, 48'(out_valid1), 48'd1);
      chk(name, dout1, ed);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ap_rst = 1'b1; rst1 = 1'b1; ce = 1'b1; ce1 = 1'b1;
      in_valid = 1'b0; din0 = '0; din1 = '0; acc_en = 1'b0; acc_clr = 1'b0;
      in_valid1 = 1'b0; din0_1 = '0; din1_1 = '0; acc_en1 = 1'b0; acc_clr1 = 1'b0;
      #1;
      chk("rst_valid", 48'(out_valid), 48'd0);
      chk("rst_dout", dout, 48'd0);
      chk("rst_ovf", 48'(acc_ovf), 48'd0);
      chk("rst1_valid", 48'(out_valid1), 48'd0);
      chk("rst1_dout", dout1, 48'd0);
      repeat (2) @(posedge ap_clk);
      #2 ap_rst = 1'b0; rst1 = 1'b0;
      @(posedge ap_clk); #1;

      // Latency / plain multiply: (-2^15)*(-2^26) = 2^41
      send(1, -32768, -67108864, 0, 0, 1, 48'd2199023255552, 1'b0);
      drain();

      // Accumulate chain
      send(1, 3, 4, 1, 1, 1, 48'd12, 1'b0);
      send(1, 5, 6, 1, 0, 1, 48'd42, 1'b0);
      send(1, -7, 2, 1, 0, 1, 48'd28, 1'b0);
      drain();

      // Same chain with a two-cycle ce stall after the second sample
      send(1, 3, 4, 1, 1, 1, 48'd12, 1'b0);
      send(1, 5, 6, 1, 0, 1, 48'd42, 1'b0);
      stall(2);
      send(1, -7, 2, 1, 0, 1, 48'd28, 1'b0);
      idle(1);
      stall(2);
      drain();

      // Bubbles and multiply-mode samples inside an accumulate chain
      send(1, 2, 3, 1, 1, 1, 48'd6, 1'b0);
      send(0, 55, 55, 1, 1, 0, '0, 1'b0);
      send(1, 10, 10, 0, 1, 1, 48'd100, 1'b0);
      send(1, 4, 5, 1, 0, 1, 48'd26, 1'b0);
      send(0, 77, 77, 1, 0, 0, '0, 1'b0);
      send(1, 10, 10, 0, 0, 1, 48'd100, 1'b0);
      send(1, -1, 6, 1, 0, 1, 48'd20, 1'b0);
      drain();

      // Overflow wrap to -2^47, then a clearing sample
      ovf_chain();
      send(1, 5, 1, 1, 1, 1, 48'd5, 1'b0);
      drain();

      // Overflow again, then async reset with two samples in flight
      ovf_chain();
      drain();
      send(1, 10, 10, 0, 0, 0, '0, 1'b0);
      send(1, 10, 10, 0, 0, 0, '0, 1'b0);
      in_valid = 1'b0;
      #2 ap_rst = 1'b1;
      #1;
      chk("arst_valid", 48'(out_valid), 48'd0);
      chk("arst_dout", dout, 48'd0);
      chk("arst_ovf", 48'(acc_ovf), 48'd0);
      @(posedge ap_clk);
      #2 ap_rst = 1'b0;
      @(posedge ap_clk); #1;
      idle(6);
      send(1, 3, 4, 1, 1, 1, 48'd12, 1'b0);
      drain();

      // Single-stage instance: 1-edge latency, accumulate, async reset
      send1(-3, 5, 0, 0, 48'(-15), "s1_mul");
      @(posedge ap_clk); #1;
      chk("s1_bubble_valid", 48'(out_valid1), 48'd0);
      send1(7, 7, 1, 1, 48'd49, "s1_acc_clr");
      send1(2, -3, 1, 0, 48'd43, "s1_acc_add");
      #2 rst1 = 1'b1;
      #1;
      chk("s1_arst_valid", 48'(out_valid1), 48'd0);
      chk("s1_arst_dout", dout1, 48'd0);
      @(posedge ap_clk);
      #2 rst1 = 1'b0;
      @(posedge ap_clk); #1;
      chk("s1_post_rst_valid", 48'(out_valid1), 48'd0);
      send1(2, 2, 0, 0, 48'd4, "s1_resume");

      chk("queue_empty", 48'(q.size()), 48'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
